// File: rtl/amem_spy.sv
// rtl/amem_spy.sv - A-memory spy port: CPU passthrough when running, FSM-driven access when halted
// Optional full-memory clear controlled by AMEM_SPY_CLEAR_EN.
module amem_spy #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  halt,
    input  logic [ADDR_WIDTH-1:0] cpu_aadr,
    input  logic                  cpu_arp,
    input  logic                  cpu_awp,
    input  logic [DATA_WIDTH-1:0] cpu_l,
    input  logic                  spy_req,
    input  logic                  spy_wr,
    input  logic [ADDR_WIDTH-1:0] spy_addr,
    input  logic [DATA_WIDTH-1:0] spy_wdata,
    output logic                  spy_ack,
    output logic [DATA_WIDTH-1:0] spy_rdata,
    input  logic                  clr_req,
    output logic                  clr_done,
    output logic [ADDR_WIDTH-1:0] aadr,
    output logic                  arp,
    output logic                  awp,
    output logic [DATA_WIDTH-1:0] l,
    input  logic [DATA_WIDTH-1:0] amem
);

`ifdef AMEM_SPY_CLEAR_EN
    typedef enum logic [2:0] {IDLE, RD, RDW, WR, ACK, CLR} state_t;
`else
    typedef enum logic [2:0] {IDLE, RD, RDW, WR, ACK} state_t;
`endif

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

`ifdef AMEM_SPY_CLEAR_EN
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  clr_done_q, clr_done_d;
`else
    logic                  unused_clr_req;
    assign unused_clr_req = clr_req;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
`ifdef AMEM_SPY_CLEAR_EN
            cnt_q      <= '0;
            clr_done_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
`ifdef AMEM_SPY_CLEAR_EN
            cnt_q      <= cnt_d;
            clr_done_q <= clr_done_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
`ifdef AMEM_SPY_CLEAR_EN
        cnt_d      = cnt_q;
        clr_done_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (halt) begin
`ifdef AMEM_SPY_CLEAR_EN
                    if (clr_req) begin
                        state_d = CLR;
                        cnt_d   = '0;
                    end else
`endif
                    if (spy_req) begin
                        addr_d  = spy_addr;
                        wdata_d = spy_wdata;
                        state_d = spy_wr ? WR : RD;
                    end
                end
            end
            RD:  state_d = halt ? RDW : IDLE;
            RDW: begin
                // An aborted read leaves the previous result visible.
                if (halt) begin
                    rdata_d = amem;
                    state_d = ACK;
                end else begin
                    state_d = IDLE;
                end
            end
            WR:  state_d = halt ? ACK : IDLE;
            ACK: begin
                if (!spy_req) state_d = IDLE;
            end
`ifdef AMEM_SPY_CLEAR_EN
            CLR: begin
                if (!halt) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ADDR_WIDTH'(1);
                    if (cnt_q == '1) begin
                        state_d    = IDLE;
                        clr_done_d = 1'b1;
                    end
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        aadr = addr_q;
        l    = wdata_q;
        arp  = 1'b0;
        awp  = 1'b0;
        if (!halt) begin
            aadr = cpu_aadr;
            l    = cpu_l;
            arp  = cpu_arp;
            awp  = cpu_awp;
        end else begin
            case (state_q)
                RD: arp = 1'b1;
                WR: awp = 1'b1;
`ifdef AMEM_SPY_CLEAR_EN
                CLR: begin
                    aadr = cnt_q;
                    l    = '0;
                    awp  = 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

    assign spy_ack   = (state_q == ACK);
    assign spy_rdata = rdata_q;
`ifdef AMEM_SPY_CLEAR_EN
    assign clr_done  = clr_done_q;
`else
    assign clr_done  = 1'b0;
`endif

endmodule
